// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RISC-V M-extension multiply/divide sequencer beside the EX ALU.
// Define MULDIV_REUSE_EN to return the last divide's stored quotient/remainder for matching operands.
module muldiv_sequencer #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
    localparam logic [4:0] OP_MUL = 5'b01010, OP_MULH = 5'b01011, OP_MULHU = 5'b01101;
    localparam logic [4:0] OP_DIV = 5'b01110, OP_REM = 5'b10000, OP_REMU = 5'b10001;
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   a_r, b_r, rem_r;
    logic              a_s, b_s, neg_q, neg_r;
    logic              is_md, is_div, is_rem, sdiv, a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf, hit;
    logic [XLEN-1:0]   a_abs, b_abs, special_res, hit_res, mul_res, div_res, q_nxt, r_nxt, q_fix, r_fix;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN:0]     shifted, diff;

    always_comb begin
        is_md       = valid_i && alu_op_i >= OP_MUL && alu_op_i <= OP_REMU;
        is_div      = alu_op_i >= OP_DIV;
        is_rem      = alu_op_i[4];
        sdiv        = alu_op_i == OP_DIV || alu_op_i == OP_REM;
        a_sgn       = alu_op_i != OP_MULHU;
        b_sgn       = alu_op_i == OP_MUL || alu_op_i == OP_MULH;
        a_neg       = sdiv && op_a_i[XLEN-1];
        b_neg       = sdiv && op_b_i[XLEN-1];
        a_abs       = a_neg ? -op_a_i : op_a_i;
        b_abs       = b_neg ? -op_b_i : op_b_i;
        div_zero    = op_b_i == '0;
        ovf         = sdiv && op_a_i == MIN && &op_b_i;
        special_res = div_zero ? (is_rem ? op_a_i : '1) : (is_rem ? '0 : MIN);
        // low half of a 2*XLEN product is sign-correct modulo 2^(2*XLEN)
        ma          = {{XLEN{a_s & a_r[XLEN-1]}}, a_r};
        mb          = {{XLEN{b_s & b_r[XLEN-1]}}, b_r};
        prod        = ma * mb;
        mul_res     = op_r == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        // restoring step: dividend shifts out of a_r, quotient bits shift in
        shifted     = {rem_r, a_r[XLEN-1]};
        diff        = shifted - {1'b0, b_r};
        r_nxt       = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        q_nxt       = {a_r[XLEN-2:0], ~diff[XLEN]};
        q_fix       = neg_q ? -q_nxt : q_nxt;
        r_fix       = neg_r ? -r_nxt : r_nxt;
        div_res     = op_r[4] ? r_fix : q_fix;
        stall_o     = is_md && !done_o;
        busy_o      = state != IDLE;
        done_o      = state == DONE;
    end

`ifdef MULDIV_REUSE_EN
    logic [XLEN-1:0] key_a, key_b, st_q, st_r;
    logic            key_s, key_v;

    assign hit     = key_v && is_div && op_a_i == key_a && op_b_i == key_b && key_s == sdiv;
    assign hit_res = is_rem ? st_r : st_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            key_a <= '0;
            key_b <= '0;
            st_q  <= '0;
            st_r  <= '0;
            key_s <= 1'b0;
            key_v <= 1'b0;
        end else if (kill_i) begin
            key_v <= 1'b0;
        end else if (state == IDLE && is_md && is_div && !hit) begin
            key_a <= op_a_i;
            key_b <= op_b_i;
            key_s <= sdiv;
            key_v <= div_zero || ovf;
            st_q  <= div_zero ? '1 : MIN;
            st_r  <= div_zero ? op_a_i : '0;
        end else if (state == DIV && cnt == '0) begin
            st_q  <= q_fix;
            st_r  <= r_fix;
            key_v <= 1'b1;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            rem_r    <= '0;
            a_s      <= 1'b0;
            b_s      <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else if (kill_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (is_md) begin
                    op_r  <= alu_op_i;
                    a_s   <= a_sgn;
                    b_s   <= b_sgn;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    a_r   <= is_div ? a_abs : op_a_i;
                    b_r   <= is_div ? b_abs : op_b_i;
                    rem_r <= '0;
                    if (is_div && (div_zero || ovf || hit)) begin
                        state    <= DONE;
                        result_o <= hit ? hit_res : special_res;
                    end else begin
                        state <= is_div ? DIV : MUL;
                        cnt   <= is_div ? CW'(XLEN-1) : CW'(MUL_LATENCY-1);
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CW'(1);
                    if (state == DIV) begin
                        a_r   <= q_nxt;
                        rem_r <= r_nxt;
                    end
                    if (cnt == '0) begin
                        state    <= DONE;
                        result_o <= state == DIV ? div_res : mul_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scoreboard bench for muldiv_sequencer (XLEN=32, MUL_LATENCY=2).
module tb_muldiv_sequencer;
    localparam logic [4:0] MUL = 5'b01010, MULH = 5'b01011, MULHSU = 5'b01100, MULHU = 5'b01101;
    localparam logic [4:0] DIV = 5'b01110, DIVU = 5'b01111, REM = 5'b10000, REMU = 5'b10001;
`ifdef MULDIV_REUSE_EN
    localparam int RL = 1;
`else
    localparam int RL = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, kill = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        stall, busy, done;
    logic [31:0] res;
    int          checks = 0, errors = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .alu_op_i(op), .op_a_i(a), .op_b_i(b),
        .kill_i(kill), .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(res)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input int l);
        exp_t want;
        int   lat;
        @(negedge clk);
        valid = 1'b1; op = o; a = x; b = y;
        sb.push_back('{res: e, lat: l});
        @(posedge clk);
        for (lat = 1; lat <= 100; lat++) begin
            #1;
            if (done) break;
            @(posedge clk);
        end
        want = sb.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, res, want.res);
        check({tag, "_latency"}, 32'(lat), 32'(want.lat));
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", res, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_neg2x3",     MUL,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 3);
        run_op("mulhu_neg2x3",   MULHU,  32'hFFFFFFFE, 32'd3,        32'h00000002, 3);
        run_op("mulh_neg2x3",    MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 3);
        run_op("mulhsu_neg2x3",  MULHSU, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 3);
        run_op("mulhu_max",      MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
        run_op("mul_max",        MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3);
        run_op("mulhsu_max",     MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        run_op("div_m7_2",       DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_m7_2",       REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, RL);
        run_op("divu_100_7",     DIVU,   32'd100,      32'd7,        32'd14,       33);
        run_op("remu_100_7",     REMU,   32'd100,      32'd7,        32'd2,        RL);
        run_op("div_7_m2",       DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_m7_m2",      REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33);
        run_op("divu_big_2",     DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
        run_op("divu_min_max",   DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("divu_by0",       DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_by0",       REMU,   32'h12345678, 32'd0,        32'h12345678, 1);
        run_op("div_by0",        DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_by0",        REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        run_op("div_ovf",        DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",        REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("div_100_7",      DIV,    32'd100,      32'd7,        32'd14,       33);
        run_op("rem_100_7",      REM,    32'd100,      32'd7,        32'd2,        RL);
        run_op("remu_sign_diff", REMU,   32'd100,      32'd7,        32'd2,        33);
        // kill an in-flight divide
        @(negedge clk);
        valid = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_done", 32'(done), 32'd0);
        check("kill_stall_valid", 32'(stall), 32'd1);
        @(negedge clk);
        kill = 1'b0; valid = 1'b0;
        #1;
        check("kill_stall_idle", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("kill_no_done", 32'(seen), 32'd0);
        run_op("mul_after_kill", MUL, 32'd7, 32'd6, 32'd42, 3);
        // reset in the middle of a divide
        @(negedge clk);
        valid = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; op = 5'b00000; a = 32'd5; b = 32'd6;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("nonm_stall", 32'(stall), 32'd0);
            check("nonm_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;
        run_op("remu_after_rst", REMU, 32'd100, 32'd7, 32'd2, 33);
        if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the M-extension ALU ops (mul, mulh, mulhsu, mulhu, div, divu, rem, remu; 5-bit ALU op codes 01010..10001).
- Sits beside the single-cycle ALU in EX. Accepts an op from the ALU decoder, runs a staged multiply or a radix-2 restoring divide, and stalls the pipeline until the result is ready.
- Owns the iteration counter, the operand/partial-result registers and RISC-V divide special-case handling.

Parameters:
- XLEN, 32, operand/result width
- MUL_LATENCY, 2, cycles spent in MUL state (1..4)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- valid_i  in  1  EX holds a valid instruction
- alu_op_i  in  5  ALU op code from the decoder
- op_a_i  in  XLEN  rs1 value
- op_b_i  in  XLEN  rs2 value
- kill_i  in  1  pipeline flush; aborts the in-flight op
- stall_o  out  1  hold IF/ID/EX
- busy_o  out  1  sequencer not in IDLE
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  XLEN  result, valid when done_o=1

Behaviour:
- Reset: rst_n_i=0 at a clk_i edge gives state=IDLE, done_o=0, busy_o=0, result_o=0, counter=0 and operand regs=0. This applies from any state, including mid-divide.
- is_md = valid_i && alu_op_i in 01010..10001.
- stall_o = is_md && !done_o (combinational). EX keeps valid_i, op and operands stable while stalled.
- States: IDLE, MUL, DIV, DONE.
- IDLE, is_md, !kill_i at edge T: latch operands, op, and sign flags.
  - Div op with op_b=0 → DONE.
  - Signed div/rem with op_a=0x80000000 and op_b=0xFFFFFFFF → DONE.
  - Other mul → MUL, counter=MUL_LATENCY-1.
  - Other div → DIV, counter=XLEN-1.
- MUL: forms the 2*XLEN product across stages. Signedness: mul/mulh signed×signed, mulhsu signed×unsigned, mulhu unsigned×unsigned. Decrement counter; at 0 go to DONE.
  - mul returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- DIV: one restoring step per cycle on magnitudes (signed ops take the absolute value at latch). Decrement counter; at 0 go to DONE.
- DONE: done_o=1 with result_o valid; next state IDLE. Sign fixup is applied when entering DONE:
  - quotient negated if signs differ
  - remainder takes the dividend's sign
- Divide by zero: quotient=0xFFFFFFFF for div and divu; remainder=op_a for rem and remu.
- Signed overflow: div → 0x80000000, rem → 0.
- Latency from accept edge T:
  - special cases: done_o in cycle T+1
  - mul: T+MUL_LATENCY+1
  - div: T+XLEN+1 (T+33)
- The pipeline advances on done_o. A new op can be accepted the cycle after DONE, in IDLE. There are no back-to-back accepts in DONE.
- kill_i=1 in any state: next state IDLE with no done_o. If kill_i and an is_md op arrive in IDLE together, the op is not accepted.
- Non-M op with valid_i: ignored; stall_o=0.
- result_o holds its last value outside DONE.

Optional Feature:
- Macro MULDIV_REUSE_EN.
- Defined: on completion of any div-family op, store quotient, remainder, op_a, op_b and signedness. A later div/rem whose operands and signedness match the stored values, with no intervening reset, goes IDLE→DONE and returns the stored result in cycle T+1.
  - Example: div followed by rem on the same operands.
  - kill_i or reset invalidates the stored entry.
- Undefined: no stored-result logic; every divide takes the full latency.

Test Plan:
- mul, op_a=0xFFFFFFFE, op_b=3, MUL_LATENCY=2 → done_o at T+3, result_o=0xFFFFFFFA; mulhu same operands → 0x00000002; mulh → 0xFFFFFFFF.
- div op_a=-7 (0xFFFFFFF9), op_b=2 → done at T+33, quotient 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 100/7 → 14; remu → 2.
- divu by zero with op_a=0x12345678 → done at T+1, result 0xFFFFFFFF; remu → 0x12345678; div 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; rem → 0.
- kill_i asserted at T+10 of a div → IDLE at T+11, no done_o, stall_o follows valid_i; the next mul is accepted and completes normally.
- rst_n_i=0 at T+5 of a div → all outputs 0, busy_o=0 the next cycle; a non-M op with valid_i gives stall_o=0 throughout.
- MULDIV_REUSE_EN: div 100/7 then rem 100/7 → rem done at T+1 with 2. Without the macro → rem takes T+33.
